data_buffer: RTL and testbench
==============================

Name: data_buffer

Overview:
- 64-byte, 8-bit-wide, single-clock FIFO at the centre of the AHB-to-USB endpoint.
- Carries data in both directions:
  - TX path: the AHB slave writes bytes; the USB TX encoder reads them.
  - RX path: the USB RX decoder writes bytes; the AHB slave reads them.
- Only one direction is in use at a time, so both paths share one storage array, one write pointer, one read pointer and one occupancy count.

Parameters:
- DATA_WIDTH, 8, byte width of each entry and of all data ports.
- ADDR_BITS, 6, pointer width; depth = 2**ADDR_BITS = 64 entries.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- n_rst  in  1  reset, synchronous, active-high (1 = reset on the next rising clk edge; name kept per codebase convention).
- clear  in  1  AHB-side buffer clear; empties the FIFO.
- flush  in  1  USB-side buffer flush; empties the FIFO (same effect as clear).
- store_tx_data  in  1  push tx_data (AHB write, TX direction).
- tx_data  in  8  byte pushed by store_tx_data.
- store_rx_packet_data  in  1  push rx_packet_data (USB RX write).
- rx_packet_data  in  8  byte pushed by store_rx_packet_data.
- get_tx_packet_data  in  1  pop head byte into tx_packet_data.
- get_rx_data  in  1  pop head byte into rx_data.
- buffer_occupancy  out  7  number of valid bytes, 0..64.
- tx_packet_data  out  8  registered byte last popped via get_tx_packet_data.
- rx_data  out  8  registered byte last popped via get_rx_data.

Behaviour:
- Priority per rising edge: n_rst > (clear | flush) > push/pop.
- Reset (n_rst=1 at edge):
  - write pointer, read pointer and buffer_occupancy = 0.
  - rx_data = 0, tx_packet_data = 0.
  - Storage contents need not be cleared.
  - Reset asserted mid-operation discards all contents.
- clear or flush (either high at edge): same as reset for pointers, occupancy and both data outputs. No other operation occurs that cycle.
- Push:
  - Valid when either store strobe is high and occupancy < 64.
  - The byte is written at the write pointer; the pointer increments modulo 64 (natural 6-bit wrap).
  - If both store strobes are high, only tx_data is written; the rx_packet_data byte is dropped.
  - A push when full (occupancy = 64) is ignored: no state change.
- Pop:
  - Valid when either get strobe is high and occupancy > 0.
  - The head entry loads into the selected output register at that edge. The read pointer increments modulo 64.
  - The popped byte is visible on the output immediately after the edge (1-cycle latency from strobe sample) and holds until the next pop of that output or a reset/clear/flush.
  - If both get strobes are high, only get_tx_packet_data is serviced; rx_data holds.
  - A pop when empty is ignored: outputs hold, pointers and occupancy unchanged.
- Occupancy after each edge:
  - Push only: +1.
  - Pop only: −1.
  - Simultaneous valid push and pop: unchanged; both pointers advance.
  - When empty, a simultaneous push/pop performs only the push (+1). When full, it performs only the pop (−1).
- buffer_occupancy is a register, updated on the same edge as the pointers. No combinational path from inputs to outputs.
- One strobe-high cycle = one transfer. Strobes held high for N cycles transfer N bytes.

Optional Feature:
- Macro DATABUFFER_ERROR_FLAG_EN.
- Defined: adds output port `error` (1 bit, registered, sticky).
  - Set on any ignored push (full) or ignored pop (empty).
  - Cleared only by n_rst, clear or flush.
- Undefined: port and logic absent. Ignored pushes and pops remain silent.

Test Plan:
- Reset: drive n_rst=1 for 2 edges -> occupancy=0, rx_data=0x00, tx_packet_data=0x00.
- TX path: 1-cycle store_tx_data with 0xAF, then 0xFA -> occupancy 1 then 2. Then two 1-cycle get_tx_packet_data -> tx_packet_data 0xAF (occ 1), then 0xFA (occ 0).
- RX path: store_rx_packet_data 0xAF, 0xFA -> occupancy 2. Then two get_rx_data -> rx_data 0xAF then 0xFA; occupancy 0; tx_packet_data unchanged.
- Clear/flush:
  - 2 RX bytes stored, 1-cycle clear -> occupancy 0, both outputs 0x00.
  - Repeat with 2 TX bytes and flush -> same result.
- Full/wrap:
  - 64 pushes of 0x00..0x3F -> occupancy 64.
  - 65th push (0x99) ignored.
  - Pop 1 -> 0x00; push 0x40; pop 64 -> 0x01..0x40 in order; occupancy 0.
  - Extra pop ignored (output holds 0x40).
- Simultaneous:
  - occupancy 3 with store_tx_data and get_rx_data together -> occupancy stays 3, rx_data = head.
  - Both store strobes (0x11 tx, 0x22 rx) at occupancy 0 -> occupancy 1; next pop returns 0x11.

Source files
------------

// File: rtl/data_buffer.sv
// Shared 64-byte TX/RX FIFO between the AHB slave and the USB endpoint.
// Optional sticky error flag: define DATABUFFER_ERROR_FLAG_EN.
module data_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  input  logic                  flush,
  input  logic                  store_tx_data,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  store_rx_packet_data,
  input  logic [DATA_WIDTH-1:0] rx_packet_data,
  input  logic                  get_tx_packet_data,
  input  logic                  get_rx_data,
  output logic [ADDR_BITS:0]    buffer_occupancy,
  output logic [DATA_WIDTH-1:0] tx_packet_data,
`ifdef DATABUFFER_ERROR_FLAG_EN
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  error
`else
  output logic [DATA_WIDTH-1:0] rx_data
`endif
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_CNT =
    (ADDR_BITS + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  wptr;
  logic [ADDR_BITS-1:0]  rptr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wipe;
  logic                  push_req;
  logic                  pop_req;
  logic                  full;
  logic                  empty;
  logic                  push_ok;
  logic                  pop_ok;

  assign wipe     = n_rst | clear | flush;
  assign push_req = store_tx_data | store_rx_packet_data;
  assign pop_req  = get_tx_packet_data | get_rx_data;
  assign full     = (buffer_occupancy == FULL_CNT);
  assign empty    = (buffer_occupancy == '0);
  assign push_ok  = push_req & ~full & ~wipe;
  assign pop_ok   = pop_req & ~empty & ~wipe;
  // TX side wins when both directions strobe together
  assign wdata    = store_tx_data ? tx_data : rx_packet_data;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      wptr             <= '0;
      rptr             <= '0;
      buffer_occupancy <= '0;
      tx_packet_data   <= '0;
      rx_data          <= '0;
    end else begin
      if (push_ok) wptr <= wptr + ADDR_BITS'(1);
      if (pop_ok) begin
        rptr <= rptr + ADDR_BITS'(1);
        if (get_tx_packet_data) tx_packet_data <= mem[rptr];
        else                    rx_data        <= mem[rptr];
      end
      unique case (1'b1)
        (push_ok && !pop_ok):
          buffer_occupancy <= buffer_occupancy + (ADDR_BITS + 1)'(1);
        (pop_ok && !push_ok):
          buffer_occupancy <= buffer_occupancy - (ADDR_BITS + 1)'(1);
        default: ;
      endcase
    end
  end

`ifdef DATABUFFER_ERROR_FLAG_EN
  always_ff @(posedge clk) begin
    if (wipe)
      error <= 1'b0;
    else if ((push_req && full) || (pop_req && empty))
      error <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_data_buffer.sv
// Directed testbench for data_buffer: reset, both paths, clear/flush,
// full/wrap and simultaneous-strobe cases.
module tb_data_buffer;

  logic       tb_clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       clear = 1'b0;
  logic       flush = 1'b0;
  logic       store_tx_data = 1'b0;
  logic [7:0] tx_data = '0;
  logic       store_rx_packet_data = 1'b0;
  logic [7:0] rx_packet_data = '0;
  logic       get_tx_packet_data = 1'b0;
  logic       get_rx_data = 1'b0;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic [7:0] rx_data;
`ifdef DATABUFFER_ERROR_FLAG_EN
  logic       error;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 tb_clk = ~tb_clk;

  data_buffer dut (
    .clk                  (tb_clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .flush                (flush),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .get_rx_data          (get_rx_data),
    .buffer_occupancy     (buffer_occupancy),
    .tx_packet_data       (tx_packet_data),
`ifdef DATABUFFER_ERROR_FLAG_EN
    .rx_data              (rx_data),
    .error                (error)
`else
    .rx_data              (rx_data)
`endif
  );

  task automatic cyc();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    store_tx_data = 1'b1;
    tx_data = b;
    cyc();
    store_tx_data = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    store_rx_packet_data = 1'b1;
    rx_packet_data = b;
    cyc();
    store_rx_packet_data = 1'b0;
  endtask

  task automatic pop_tx();
    get_tx_packet_data = 1'b1;
    cyc();
    get_tx_packet_data = 1'b0;
  endtask

  task automatic pop_rx();
    get_rx_data = 1'b1;
    cyc();
    get_rx_data = 1'b0;
  endtask

  task automatic chk_occ(input string nm, input logic [6:0] exp);
    vectors++;
    if (buffer_occupancy !== exp) begin
      miscompares++;
      $display("FAIL %s: occupancy got %0d want %0d",
               nm, buffer_occupancy, exp);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    cyc();
    cyc();
    n_rst = 1'b0;
    chk_occ("reset_occ", 7'd0);
    vectors++;
    if (rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rx: got %h want 00", rx_data);
    end
    vectors++;
    if (tx_packet_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_tx: got %h want 00", tx_packet_data);
    end
  endtask

  task automatic test_tx_path();
    push_tx(8'hAF);
    chk_occ("tx_push1", 7'd1);
    push_tx(8'hFA);
    chk_occ("tx_push2", 7'd2);
    pop_tx();
    vectors++;
    if (tx_packet_data !== 8'hAF) begin
      miscompares++;
      $display("FAIL tx_pop1: got %h want af", tx_packet_data);
    end
    chk_occ("tx_pop1_occ", 7'd1);
    pop_tx();
    vectors++;
    if (tx_packet_data !== 8'hFA) begin
      miscompares++;
      $display("FAIL tx_pop2: got %h want fa", tx_packet_data);
    end
    chk_occ("tx_pop2_occ", 7'd0);
  endtask

  task automatic test_rx_path();
    push_rx(8'hAF);
    push_rx(8'hFA);
    chk_occ("rx_push2", 7'd2);
    pop_rx();
    vectors++;
    if (rx_data !== 8'hAF) begin
      miscompares++;
      $display("FAIL rx_pop1: got %h want af", rx_data);
    end
    pop_rx();
    vectors++;
    if (rx_data !== 8'hFA) begin
      miscompares++;
      $display("FAIL rx_pop2: got %h want fa", rx_data);
    end
    chk_occ("rx_pop2_occ", 7'd0);
    vectors++;
    if (tx_packet_data !== 8'hFA) begin
      miscompares++;
      $display("FAIL rx_tx_hold: got %h want fa", tx_packet_data);
    end
  endtask

  task automatic test_clear_flush();
    push_rx(8'h12);
    push_rx(8'h34);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk_occ("clear_occ", 7'd0);
    vectors++;
    if (rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin
      miscompares++;
      $display("FAIL clear_out: got rx=%h tx=%h want 00/00",
               rx_data, tx_packet_data);
    end
    push_tx(8'h56);
    pop_rx();
    push_tx(8'h78);
    push_tx(8'h9A);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk_occ("flush_occ", 7'd0);
    vectors++;
    if (rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin
      miscompares++;
      $display("FAIL flush_out: got rx=%h tx=%h want 00/00",
               rx_data, tx_packet_data);
    end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 64; i++) push_tx(8'(i));
    chk_occ("full_occ", 7'd64);
    push_tx(8'h99);
    chk_occ("full_ignored", 7'd64);
    pop_tx();
    vectors++;
    if (tx_packet_data !== 8'h00) begin
      miscompares++;
      $display("FAIL full_pop0: got %h want 00", tx_packet_data);
    end
    chk_occ("full_pop0_occ", 7'd63);
    push_tx(8'h40);
    chk_occ("wrap_push_occ", 7'd64);
    for (int i = 1; i <= 64; i++) begin
      pop_tx();
      vectors++;
      if (tx_packet_data !== 8'(i)) begin
        miscompares++;
        $display("FAIL wrap_pop%0d: got %h want %h",
                 i, tx_packet_data, 8'(i));
      end
    end
    chk_occ("wrap_empty", 7'd0);
    pop_tx();
    vectors++;
    if (tx_packet_data !== 8'h40) begin
      miscompares++;
      $display("FAIL empty_pop_hold: got %h want 40", tx_packet_data);
    end
    chk_occ("empty_pop_occ", 7'd0);
  endtask

  task automatic test_simultaneous();
    push_tx(8'h01);
    push_tx(8'h02);
    push_tx(8'h03);
    chk_occ("sim_pre", 7'd3);
    store_tx_data = 1'b1;
    tx_data = 8'h04;
    get_rx_data = 1'b1;
    cyc();
    store_tx_data = 1'b0;
    get_rx_data = 1'b0;
    chk_occ("sim_pushpop", 7'd3);
    vectors++;
    if (rx_data !== 8'h01) begin
      miscompares++;
      $display("FAIL sim_rx: got %h want 01", rx_data);
    end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    store_tx_data = 1'b1;
    tx_data = 8'h11;
    store_rx_packet_data = 1'b1;
    rx_packet_data = 8'h22;
    cyc();
    store_tx_data = 1'b0;
    store_rx_packet_data = 1'b0;
    chk_occ("both_store", 7'd1);
    pop_rx();
    vectors++;
    if (rx_data !== 8'h11) begin
      miscompares++;
      $display("FAIL both_store_pop: got %h want 11", rx_data);
    end
    chk_occ("both_store_empty", 7'd0);
    push_rx(8'h55);
    get_tx_packet_data = 1'b1;
    get_rx_data = 1'b1;
    cyc();
    get_tx_packet_data = 1'b0;
    get_rx_data = 1'b0;
    vectors++;
    if (tx_packet_data !== 8'h55 || rx_data !== 8'h11) begin
      miscompares++;
      $display("FAIL both_get: got tx=%h rx=%h want 55/11",
               tx_packet_data, rx_data);
    end
  endtask

  task automatic test_mid_reset();
    push_tx(8'hC3);
    push_tx(8'h3C);
    pop_rx();
    n_rst = 1'b1;
    cyc();
    n_rst = 1'b0;
    chk_occ("midrst_occ", 7'd0);
    vectors++;
    if (rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_out: got rx=%h tx=%h want 00/00",
               rx_data, tx_packet_data);
    end
    push_rx(8'hE7);
    pop_tx();
    vectors++;
    if (tx_packet_data !== 8'hE7) begin
      miscompares++;
      $display("FAIL midrst_reuse: got %h want e7", tx_packet_data);
    end
  endtask

  initial begin
    test_reset();
    test_tx_path();
    test_rx_path();
    test_clear_flush();
    test_full_wrap();
    test_simultaneous();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
